// File: rtl/cuenta_unos_param.sv
// Serial bit counter: captures a W-bit word on Start and counts its ones (Modo=0)
// or zeros (Modo=1) one bit per clock, then holds the result with Fin raised.
module cuenta_unos_param #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  Q,
  input  logic          Start,
  input  logic          Modo,
  output logic [CW-1:0] Cuenta,
  output logic          Fin,
  output logic          Ocupado
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {REPOSO, CONTAR, FIN} estado_t;

  estado_t       estado, estado_nx;
  logic [W-1:0]  sr, sr_nx;
  logic          modo_r, modo_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [CW-1:0] cuenta, cuenta_nx;
  logic          fin, fin_nx;
  logic          ocupado, ocupado_nx;

  always_comb begin
    estado_nx  = estado;
    sr_nx      = sr;
    modo_nx    = modo_r;
    idx_nx     = idx;
    cuenta_nx  = cuenta;
    fin_nx     = fin;
    ocupado_nx = ocupado;
    case (estado)
      REPOSO, FIN: begin
        // A restart from FIN is identical to a start from REPOSO.
        if (Start) begin
          sr_nx      = Q;
          modo_nx    = Modo;
          cuenta_nx  = '0;
          idx_nx     = '0;
          ocupado_nx = 1'b1;
          fin_nx     = 1'b0;
          estado_nx  = CONTAR;
        end
      end
      CONTAR: begin
        cuenta_nx = cuenta + {{(CW-1){1'b0}}, sr[0] ^ modo_r};
        sr_nx     = sr >> 1;
        idx_nx    = idx + IW'(1);
        if (idx == IW'(W - 1)) begin
          estado_nx  = FIN;
          ocupado_nx = 1'b0;
          fin_nx     = 1'b1;
        end
      end
      default: estado_nx = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado  <= REPOSO;
      sr      <= '0;
      modo_r  <= 1'b0;
      idx     <= '0;
      cuenta  <= '0;
      fin     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      estado  <= estado_nx;
      sr      <= sr_nx;
      modo_r  <= modo_nx;
      idx     <= idx_nx;
      cuenta  <= cuenta_nx;
      fin     <= fin_nx;
      ocupado <= ocupado_nx;
    end
  end

  assign Cuenta  = cuenta;
  assign Fin     = fin;
  assign Ocupado = ocupado;

endmodule

// File: tb/tb_cuenta_unos_param.sv
// Directed bench for cuenta_unos_param: one W=8 instance and one W=3 instance,
// expected counts worked out by hand from the stimulus words.
module tb_cuenta_unos_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] q8;
  logic       start8, modo8;
  logic [3:0] cuenta8;
  logic       fin8, ocupado8;
  logic [2:0] q3;
  logic       start3, modo3;
  logic [1:0] cuenta3;
  logic       fin3, ocupado3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cuenta_unos_param #(.W(8)) u_dut8 (
    .clk(clk), .reset(reset), .Q(q8), .Start(start8), .Modo(modo8),
    .Cuenta(cuenta8), .Fin(fin8), .Ocupado(ocupado8)
  );

  cuenta_unos_param #(.W(3)) u_dut3 (
    .clk(clk), .reset(reset), .Q(q3), .Start(start3), .Modo(modo3),
    .Cuenta(cuenta3), .Fin(fin3), .Ocupado(ocupado3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input int c, input int f, input int o);
    check({tag, ".cuenta"}, int'(cuenta8), c);
    check({tag, ".fin"}, int'(fin8), f);
    check({tag, ".ocupado"}, int'(ocupado8), o);
  endtask

  // One-cycle Start on the W=8 unit, then check the result at edge k+8.
  task automatic run8(input string tag, input logic [7:0] q, input logic m, input int exp);
    q8 = q; modo8 = m; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check8({tag, ".k"}, 0, 0, 1);
    repeat (7) tick();
    check8({tag, ".k7"}, -1 == 0 ? 0 : int'(cuenta8), 0, 1);
    tick();
    check8({tag, ".k8"}, exp, 1, 0);
  endtask

  initial begin
    reset = 1'b1; q8 = '0; start8 = 1'b0; modo8 = 1'b0;
    q3 = '0; start3 = 1'b0; modo3 = 1'b0;

    // Reset two cycles, then idle three.
    repeat (2) begin
      tick();
      check8("rst", 0, 0, 0);
    end
    reset = 1'b0;
    repeat (3) begin
      tick();
      check8("idle", 0, 0, 0);
      check("idle3.fin", int'(fin3), 0);
    end

    // 1011_0010, Modo=0: running count 0,1,1,1,2,3,3,4 over edges k+1..k+8.
    q8 = 8'b1011_0010; modo8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check8("basic.k", 0, 0, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("basic.ocupado", int'(ocupado8), 1);
      check("basic.fin", int'(fin8), 0);
      if (i == 5) check("basic.running", int'(cuenta8), 2);
    end
    tick();
    check8("basic.k8", 4, 1, 0);
    repeat (2) tick();
    check8("basic.hold", 4, 1, 0);

    // Restarts from FIN: all ones, all ones counted as zeros, all zeros as zeros.
    run8("ff_ones", 8'hFF, 1'b0, 8);
    run8("ff_zeros", 8'hFF, 1'b1, 0);
    run8("00_zeros", 8'h00, 1'b1, 8);
    tick();
    check8("00_zeros.hold", 8, 1, 0);

    // Start and Q changes during CONTAR are ignored.
    q8 = 8'b1011_0010; modo8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (2) tick();
    q8 = 8'h00; modo8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("ignore.k3.cuenta", int'(cuenta8), 1);
    repeat (4) tick();
    check8("ignore.k7", 3, 0, 1);
    tick();
    check8("ignore.k8", 4, 1, 0);

    // Reset at edge k+4 aborts the count with no Fin.
    q8 = 8'hFF; modo8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    check8("abort.k3", 3, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check8("abort.k4", 0, 0, 0);
    repeat (10) begin
      tick();
      check8("abort.after", 0, 0, 0);
    end

    // Reset and Start together: reset wins, block stays idle.
    reset = 1'b1; start8 = 1'b1; q8 = 8'hFF;
    tick();
    reset = 1'b0; start8 = 1'b0;
    check8("rst_start", 0, 0, 0);
    repeat (2) tick();
    check8("rst_start.after", 0, 0, 0);

    // W=3, Q=111 with Start held: Fin at k+3, then one Fin every 4 cycles.
    q3 = 3'b111; modo3 = 1'b0; start3 = 1'b1;
    tick();
    check("w3.k.ocupado", int'(ocupado3), 1);
    check("w3.k.fin", int'(fin3), 0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("w3.fin", int'(fin3), (j % 4 == 3) ? 1 : 0);
      check("w3.ocupado", int'(ocupado3), (j % 4 == 3) ? 0 : 1);
      if (j % 4 == 3) check("w3.cuenta", int'(cuenta3), 3);
    end
    start3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
